// File: rtl/rv32i_hazard_unit.sv
// rv32i_hazard_unit
// Hazard controller for the five-stage RV32I pipeline. Produces the stage
// stall/flush controls, the EX operand forwarding selects and the four
// forwarding source buses.
// Optional feature macro: HAZARD_FWD_EN
//   defined   -> full forwarding network (EX/MEM ALU, PC+4, WB port, last write)
//   undefined -> forwarding outputs tied to zero, RAW hazards resolved by interlock

module rv32i_hazard_unit #(
    parameter logic [1:0] WB_SEL_MEM = 2'b01,
    parameter logic [1:0] WB_SEL_PC4 = 2'b10
) (
    input  logic        clk_i,
    input  logic        rst_ni,

    input  logic [31:0] ifid_instr_i,
    input  logic        ifid_valid_i,

    input  logic [4:0]  ex_rs1_addr_i,
    input  logic [4:0]  ex_rs2_addr_i,
    input  logic [4:0]  ex_rd_addr_i,
    input  logic        ex_regwrite_i,
    input  logic        ex_memread_i,
    input  logic        ex_valid_i,
    input  logic [1:0]  ex_wb_sel_i,

    input  logic        bj_taken_i,
    input  logic        mem_busy_i,

    input  logic [31:0] exmem_alu_result_i,
    input  logic [31:0] exmem_pc_i,

    input  logic        wbrf_regwrite_i,
    input  logic [4:0]  wbrf_rd_addr_i,
    input  logic [31:0] wbrf_wdata_i,

    output logic        stall_if_o,
    output logic        stall_id_o,
    output logic        stall_ex_o,
    output logic        stall_mem_o,
    output logic        flush_if_o,
    output logic        flush_id_o,
    output logic        flush_ex_o,
    output logic        flush_mem_o,

    output logic [2:0]  se0_o,
    output logic [2:0]  se1_o,
    output logic [31:0] fw_b_o,
    output logic [31:0] fw_c_o,
    output logic [31:0] fw_d_o,
    output logic [31:0] fw_e_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;

    localparam logic [2:0] SEL_RF  = 3'd0;
    localparam logic [2:0] SEL_ALU = 3'd1;
    localparam logic [2:0] SEL_PC4 = 3'd2;
    localparam logic [2:0] SEL_WB  = 3'd3;
    localparam logic [2:0] SEL_LW  = 3'd4;

    typedef enum logic {
        RUN    = 1'b0,
        FROZEN = 1'b1
    } hz_state_e;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       regwrite;
        logic       memread;
        logic [1:0] wb_sel;
    } mem_shadow_t;

    hz_state_e   state_q;
    hz_state_e   state_d;
    logic        bj_pend_q;
    logic        bj_pend_d;
    mem_shadow_t mem_q;

    logic [6:0]  id_opcode;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        rs1_used;
    logic        rs2_used;
    logic        load_use;
    logic        data_hazard;
    logic        freeze;

    assign id_opcode = ifid_instr_i[6:0];
    assign id_rs1    = ifid_instr_i[19:15];
    assign id_rs2    = ifid_instr_i[24:20];

    // Freeze follows mem_busy_i directly so it lasts exactly the busy time
    assign freeze = mem_busy_i;

    logic unused_common;
    assign unused_common = ^{ifid_instr_i[31:25], ifid_instr_i[14:7], WB_SEL_MEM};

    // Decode which IF/ID source registers the instruction really reads (x0 never counts)
    always_comb begin
        rs1_used = 1'b1;
        rs2_used = 1'b0;
        case (id_opcode)
            OPC_LUI, OPC_AUIPC, OPC_JAL:     rs1_used = 1'b0;
            OPC_OP, OPC_BRANCH, OPC_STORE:   rs2_used = 1'b1;
            default:                         ;
        endcase
        if (id_rs1 == 5'd0) begin
            rs1_used = 1'b0;
        end
        if (id_rs2 == 5'd0) begin
            rs2_used = 1'b0;
        end
    end

    // Load data only exists after MEM, so a dependent IF/ID instruction must wait one slot
    always_comb begin
        load_use = 1'b0;
        if (ifid_valid_i && ex_valid_i && ex_memread_i && (ex_rd_addr_i != 5'd0)) begin
            load_use = (rs1_used && (id_rs1 == ex_rd_addr_i)) ||
                       (rs2_used && (id_rs2 == ex_rd_addr_i));
        end
    end

`ifdef HAZARD_FWD_EN

    typedef struct packed {
        logic        valid;
        logic [4:0]  rd;
        logic [31:0] data;
    } last_write_t;

    last_write_t lw_q;

    // One-deep memory of the previous register-file write, held while frozen
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            lw_q <= '0;
        end else if (!freeze) begin
            lw_q.valid <= wbrf_regwrite_i && (wbrf_rd_addr_i != 5'd0);
            lw_q.rd    <= wbrf_rd_addr_i;
            lw_q.data  <= wbrf_wdata_i;
        end
    end

    function automatic logic [2:0] pick_source(
        input logic [4:0]  rs,
        input mem_shadow_t shadow,
        input logic        wb_wr,
        input logic [4:0]  wb_rd,
        input logic        lw_valid,
        input logic [4:0]  lw_rd
    );
        logic [2:0] sel;
        sel = SEL_RF;
        if (rs != 5'd0) begin
            if (shadow.valid && shadow.regwrite && !shadow.memread && (shadow.rd == rs)) begin
                sel = (shadow.wb_sel == WB_SEL_PC4) ? SEL_PC4 : SEL_ALU;
            end else if (wb_wr && (wb_rd == rs)) begin
                sel = SEL_WB;
            end else if (lw_valid && (lw_rd == rs)) begin
                sel = SEL_LW;
            end
        end
        return sel;
    endfunction

    // Youngest producer wins: EX/MEM result, then the WB port, then the last write
    always_comb begin
        se0_o = pick_source(ex_rs1_addr_i, mem_q, wbrf_regwrite_i, wbrf_rd_addr_i,
                            lw_q.valid, lw_q.rd);
        se1_o = pick_source(ex_rs2_addr_i, mem_q, wbrf_regwrite_i, wbrf_rd_addr_i,
                            lw_q.valid, lw_q.rd);
    end

    assign fw_b_o = exmem_alu_result_i;
    assign fw_c_o = exmem_pc_i + 32'd4;
    assign fw_d_o = wbrf_wdata_i;
    assign fw_e_o = lw_q.data;

    assign data_hazard = load_use;

`else

    logic raw_hazard;

    function automatic logic writer_match(
        input logic [4:0]  rs,
        input logic        ex_wr,
        input logic [4:0]  ex_rd,
        input mem_shadow_t shadow,
        input logic        wb_wr,
        input logic [4:0]  wb_rd
    );
        return (rs != 5'd0) &&
               ((ex_wr && (ex_rd == rs)) ||
                (shadow.valid && shadow.regwrite && (shadow.rd == rs)) ||
                (wb_wr && (wb_rd == rs)));
    endfunction

    // Without forwarding, any in-flight write to a used source holds IF/ID until it retires
    always_comb begin
        raw_hazard = (rs1_used && writer_match(id_rs1, ex_valid_i && ex_regwrite_i, ex_rd_addr_i,
                                               mem_q, wbrf_regwrite_i, wbrf_rd_addr_i)) ||
                     (rs2_used && writer_match(id_rs2, ex_valid_i && ex_regwrite_i, ex_rd_addr_i,
                                               mem_q, wbrf_regwrite_i, wbrf_rd_addr_i));
    end

    assign se0_o  = 3'd0;
    assign se1_o  = 3'd0;
    assign fw_b_o = 32'd0;
    assign fw_c_o = 32'd0;
    assign fw_d_o = 32'd0;
    assign fw_e_o = 32'd0;

    assign data_hazard = load_use || raw_hazard;

    logic unused_nofwd;
    assign unused_nofwd = ^{mem_q.memread, mem_q.wb_sel, exmem_alu_result_i, exmem_pc_i,
                            wbrf_wdata_i, ex_rs1_addr_i, ex_rs2_addr_i, WB_SEL_PC4};

`endif

    // Mode register and the branch flush owed from a busy period
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= RUN;
            bj_pend_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            bj_pend_q <= bj_pend_d;
        end
    end

    // Next mode plus stall/flush decision: freeze, then branch flush, then data hazard
    always_comb begin
        state_d     = state_q;
        bj_pend_d   = bj_pend_q;
        stall_if_o  = 1'b0;
        stall_id_o  = 1'b0;
        stall_ex_o  = 1'b0;
        stall_mem_o = 1'b0;
        flush_if_o  = 1'b0;
        flush_id_o  = 1'b0;
        flush_ex_o  = 1'b0;
        flush_mem_o = 1'b0;

        case (state_q)
            RUN:    if (mem_busy_i)  state_d = FROZEN;
            FROZEN: if (!mem_busy_i) state_d = RUN;
        endcase

        if (!rst_ni) begin
            bj_pend_d = 1'b0;
        end else if (freeze) begin
            stall_if_o  = 1'b1;
            stall_id_o  = 1'b1;
            stall_ex_o  = 1'b1;
            stall_mem_o = 1'b1;
            bj_pend_d   = bj_pend_q | bj_taken_i;
        end else if (bj_taken_i || bj_pend_q) begin
            flush_if_o = 1'b1;
            flush_id_o = 1'b1;
            bj_pend_d  = 1'b0;
        end else if (data_hazard) begin
            stall_if_o = 1'b1;
            flush_id_o = 1'b1;
        end
    end

    // Shadow of the instruction that has moved from EX into MEM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mem_q <= '0;
        end else if (flush_ex_o) begin
            mem_q <= '0;
        end else if (!stall_ex_o) begin
            mem_q.valid    <= ex_valid_i;
            mem_q.rd       <= ex_rd_addr_i;
            mem_q.regwrite <= ex_regwrite_i;
            mem_q.memread  <= ex_memread_i;
            mem_q.wb_sel   <= ex_wb_sel_i;
        end
    end

endmodule

// File: tb/tb_rv32i_hazard_unit.sv
// tb_rv32i_hazard_unit
// Directed and randomized checks of rv32i_hazard_unit against a behavioural
// model of the pipeline hazard rules. Follows the HAZARD_FWD_EN setting of the build.

module tb_rv32i_hazard_unit;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic [31:0] ifid_instr_i;
    logic        ifid_valid_i;
    logic [4:0]  ex_rs1_addr_i;
    logic [4:0]  ex_rs2_addr_i;
    logic [4:0]  ex_rd_addr_i;
    logic        ex_regwrite_i;
    logic        ex_memread_i;
    logic        ex_valid_i;
    logic [1:0]  ex_wb_sel_i;
    logic        bj_taken_i;
    logic        mem_busy_i;
    logic [31:0] exmem_alu_result_i;
    logic [31:0] exmem_pc_i;
    logic        wbrf_regwrite_i;
    logic [4:0]  wbrf_rd_addr_i;
    logic [31:0] wbrf_wdata_i;
    logic        stall_if_o, stall_id_o, stall_ex_o, stall_mem_o;
    logic        flush_if_o, flush_id_o, flush_ex_o, flush_mem_o;
    logic [2:0]  se0_o, se1_o;
    logic [31:0] fw_b_o, fw_c_o, fw_d_o, fw_e_o;

    always #5 clk_i = ~clk_i;

    rv32i_hazard_unit dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .ifid_instr_i(ifid_instr_i), .ifid_valid_i(ifid_valid_i),
        .ex_rs1_addr_i(ex_rs1_addr_i), .ex_rs2_addr_i(ex_rs2_addr_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_regwrite_i(ex_regwrite_i),
        .ex_memread_i(ex_memread_i), .ex_valid_i(ex_valid_i), .ex_wb_sel_i(ex_wb_sel_i),
        .bj_taken_i(bj_taken_i), .mem_busy_i(mem_busy_i),
        .exmem_alu_result_i(exmem_alu_result_i), .exmem_pc_i(exmem_pc_i),
        .wbrf_regwrite_i(wbrf_regwrite_i), .wbrf_rd_addr_i(wbrf_rd_addr_i),
        .wbrf_wdata_i(wbrf_wdata_i),
        .stall_if_o(stall_if_o), .stall_id_o(stall_id_o),
        .stall_ex_o(stall_ex_o), .stall_mem_o(stall_mem_o),
        .flush_if_o(flush_if_o), .flush_id_o(flush_id_o),
        .flush_ex_o(flush_ex_o), .flush_mem_o(flush_mem_o),
        .se0_o(se0_o), .se1_o(se1_o),
        .fw_b_o(fw_b_o), .fw_c_o(fw_c_o), .fw_d_o(fw_d_o), .fw_e_o(fw_e_o)
    );

`ifdef HAZARD_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    int checks = 0;
    int failures = 0;
    int stallSeen = 0;
    int flushSeen = 0;

    // Model state: what left EX last time the pipe moved, the previous RF write, owed branch flush
    typedef struct {
        logic       valid;
        logic [4:0] rd;
        logic       writes;
        logic       isLoad;
        logic [1:0] wbSel;
    } retired_t;

    retired_t    aheadInMem;
    logic        recentValid;
    logic [4:0]  recentRd;
    logic [31:0] recentData;
    logic        branchOwed;

    logic [3:0]  expStall;
    logic [3:0]  expFlush;
    logic [2:0]  expSe0, expSe1;
    logic [31:0] expFw [4];

    logic [6:0]  opcodes [9] = '{7'h37, 7'h17, 7'h6F, 7'h33, 7'h63, 7'h23, 7'h03, 7'h13, 7'h67};

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    function automatic bit readsRs1(input logic [31:0] ins);
        logic [6:0] opc;
        opc = ins[6:0];
        return !((opc == 7'h37) || (opc == 7'h17) || (opc == 7'h6F));
    endfunction

    function automatic bit readsRs2(input logic [31:0] ins);
        logic [6:0] opc;
        opc = ins[6:0];
        return (opc == 7'h33) || (opc == 7'h63) || (opc == 7'h23);
    endfunction

    function automatic logic [2:0] sourceFor(input logic [4:0] rs);
        if (rs == 5'd0) return 3'd0;
        if (aheadInMem.valid && aheadInMem.writes && !aheadInMem.isLoad && aheadInMem.rd == rs)
            return (aheadInMem.wbSel == 2'b10) ? 3'd2 : 3'd1;
        if (wbrf_regwrite_i && wbrf_rd_addr_i == rs) return 3'd3;
        if (recentValid && recentRd == rs) return 3'd4;
        return 3'd0;
    endfunction

    task automatic resetModel();
        aheadInMem  = '{valid: 1'b0, rd: 5'd0, writes: 1'b0, isLoad: 1'b0, wbSel: 2'd0};
        recentValid = 1'b0;
        recentRd    = 5'd0;
        recentData  = 32'd0;
        branchOwed  = 1'b0;
    endtask

    task automatic computeExpected();
        logic [4:0] rs1, rs2;
        bit         use1, use2, loadUse, raw;
        logic [4:0] writers[$];
        rs1  = ifid_instr_i[19:15];
        rs2  = ifid_instr_i[24:20];
        use1 = readsRs1(ifid_instr_i) && (rs1 != 5'd0);
        use2 = readsRs2(ifid_instr_i) && (rs2 != 5'd0);
        loadUse = ifid_valid_i && ex_valid_i && ex_memread_i && (ex_rd_addr_i != 5'd0) &&
                  ((use1 && rs1 == ex_rd_addr_i) || (use2 && rs2 == ex_rd_addr_i));
        if (ex_valid_i && ex_regwrite_i) writers.push_back(ex_rd_addr_i);
        if (aheadInMem.valid && aheadInMem.writes) writers.push_back(aheadInMem.rd);
        if (wbrf_regwrite_i) writers.push_back(wbrf_rd_addr_i);
        raw = 1'b0;
        foreach (writers[i]) begin
            if ((use1 && writers[i] == rs1) || (use2 && writers[i] == rs2)) raw = 1'b1;
        end
        expStall = 4'b0000;
        expFlush = 4'b0000;
        if (rst_ni !== 1'b1) begin
            expStall = 4'b0000;
        end else if (mem_busy_i) begin
            expStall = 4'b1111;
        end else if (bj_taken_i || branchOwed) begin
            expFlush = 4'b0011;
        end else if (loadUse || (!FWD && raw)) begin
            expStall = 4'b0001;
            expFlush = 4'b0010;
        end
        if (FWD) begin
            expSe0   = sourceFor(ex_rs1_addr_i);
            expSe1   = sourceFor(ex_rs2_addr_i);
            expFw[0] = exmem_alu_result_i;
            expFw[1] = exmem_pc_i + 32'd4;
            expFw[2] = wbrf_wdata_i;
            expFw[3] = recentData;
        end else begin
            expSe0 = 3'd0;
            expSe1 = 3'd0;
            foreach (expFw[i]) expFw[i] = 32'd0;
        end
    endtask

    task automatic compareAll();
        checkOutput("stall_if",  32'(stall_if_o),  32'(expStall[0]));
        checkOutput("stall_id",  32'(stall_id_o),  32'(expStall[1]));
        checkOutput("stall_ex",  32'(stall_ex_o),  32'(expStall[2]));
        checkOutput("stall_mem", 32'(stall_mem_o), 32'(expStall[3]));
        checkOutput("flush_if",  32'(flush_if_o),  32'(expFlush[0]));
        checkOutput("flush_id",  32'(flush_id_o),  32'(expFlush[1]));
        checkOutput("flush_ex",  32'(flush_ex_o),  32'(expFlush[2]));
        checkOutput("flush_mem", 32'(flush_mem_o), 32'(expFlush[3]));
        checkOutput("se0", 32'(se0_o), 32'(expSe0));
        checkOutput("se1", 32'(se1_o), 32'(expSe1));
        checkOutput("fw_b", fw_b_o, expFw[0]);
        checkOutput("fw_c", fw_c_o, expFw[1]);
        checkOutput("fw_d", fw_d_o, expFw[2]);
        checkOutput("fw_e", fw_e_o, expFw[3]);
    endtask

    // Inputs are set at the falling edge; sample 1 ns later
    task automatic applyStimulus();
        #1;
        computeExpected();
        compareAll();
        if (stall_if_o === 1'b1) stallSeen++;
        if (flush_if_o === 1'b1) flushSeen++;
    endtask

    // Let the rising edge happen, move the model along, return at the next falling edge
    task automatic endCycle();
        @(posedge clk_i);
        if (!mem_busy_i) begin
            aheadInMem  = '{valid: ex_valid_i, rd: ex_rd_addr_i, writes: ex_regwrite_i,
                            isLoad: ex_memread_i, wbSel: ex_wb_sel_i};
            recentValid = wbrf_regwrite_i && (wbrf_rd_addr_i != 5'd0);
            recentRd    = wbrf_rd_addr_i;
            recentData  = wbrf_wdata_i;
            branchOwed  = 1'b0;
        end else begin
            branchOwed = branchOwed || bj_taken_i;
        end
        @(negedge clk_i);
    endtask

    task automatic clearInputs();
        ifid_instr_i = 32'd0; ifid_valid_i = 1'b0;
        ex_rs1_addr_i = 5'd0; ex_rs2_addr_i = 5'd0; ex_rd_addr_i = 5'd0;
        ex_regwrite_i = 1'b0; ex_memread_i = 1'b0; ex_valid_i = 1'b0; ex_wb_sel_i = 2'd0;
        bj_taken_i = 1'b0; mem_busy_i = 1'b0;
        exmem_alu_result_i = 32'd0; exmem_pc_i = 32'd0;
        wbrf_regwrite_i = 1'b0; wbrf_rd_addr_i = 5'd0; wbrf_wdata_i = 32'd0;
    endtask

    // Small register range so producers and consumers collide often
    task automatic randomizeInputs();
        logic [31:0] ins;
        ins = $urandom;
        ins[6:0]   = opcodes[$urandom_range(0, 8)];
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        ifid_instr_i  = ins;
        ifid_valid_i  = ($urandom_range(0, 7) != 0);
        ex_valid_i    = ($urandom_range(0, 5) != 0);
        ex_regwrite_i = ex_valid_i && ($urandom_range(0, 3) != 0);
        ex_memread_i  = ($urandom_range(0, 2) == 0);
        ex_wb_sel_i   = 2'($urandom_range(0, 3));
        ex_rd_addr_i  = 5'($urandom_range(0, 3));
        ex_rs1_addr_i = 5'($urandom_range(0, 3));
        ex_rs2_addr_i = 5'($urandom_range(0, 3));
        bj_taken_i    = ($urandom_range(0, 5) == 0);
        mem_busy_i    = ($urandom_range(0, 4) == 0);
        exmem_alu_result_i = $urandom;
        exmem_pc_i         = $urandom;
        wbrf_regwrite_i    = ($urandom_range(0, 1) == 1);
        wbrf_rd_addr_i     = 5'($urandom_range(0, 3));
        wbrf_wdata_i       = $urandom;
    endtask

    initial begin
        clearInputs();
        rst_ni = 1'b0;
        resetModel();
        repeat (2) @(negedge clk_i);
        #1;
        checkOutput("reset_stall_if", 32'(stall_if_o), 32'd0);
        checkOutput("reset_flush_id", 32'(flush_id_o), 32'd0);
        checkOutput("reset_se0", 32'(se0_o), 32'd0);
        checkOutput("reset_se1", 32'(se1_o), 32'd0);
        checkOutput("reset_fw_e", fw_e_o, 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        $display("[TB] reset released");

        // ADD x3 then SUB x4,x3,x0 walking through EX, MEM and WB
        stallSeen = 0;
        ifid_valid_i = 1'b1; ifid_instr_i = 32'h40018233;
        ex_valid_i = 1'b1; ex_regwrite_i = 1'b1; ex_rd_addr_i = 5'd3;
        applyStimulus(); endCycle();
        ex_valid_i = 1'b0; ex_regwrite_i = 1'b0; ex_rd_addr_i = 5'd0;
        ex_rs1_addr_i = 5'd3; exmem_alu_result_i = 32'h1234;
        applyStimulus();
`ifdef HAZARD_FWD_EN
        checkOutput("alu_fwd_sel", 32'(se0_o), 32'd1);
        checkOutput("alu_fwd_val", fw_b_o, 32'h1234);
`endif
        endCycle();
        wbrf_regwrite_i = 1'b1; wbrf_rd_addr_i = 5'd3; wbrf_wdata_i = 32'hDEAD;
        applyStimulus();
`ifdef HAZARD_FWD_EN
        checkOutput("wb_fwd_sel", 32'(se0_o), 32'd3);
`endif
        endCycle();
        wbrf_regwrite_i = 1'b0; wbrf_rd_addr_i = 5'd0; wbrf_wdata_i = 32'd0;
        applyStimulus();
`ifdef HAZARD_FWD_EN
        checkOutput("lw_fwd_sel", 32'(se0_o), 32'd4);
        checkOutput("lw_fwd_val", fw_e_o, 32'hDEAD);
        checkOutput("raw_stall_cycles", 32'(stallSeen), 32'd0);
`else
        checkOutput("raw_stall_cycles", 32'(stallSeen), 32'd3);
`endif
        endCycle();

        // JAL x1 in MEM feeding EX rs2
        clearInputs();
        ex_valid_i = 1'b1; ex_regwrite_i = 1'b1; ex_rd_addr_i = 5'd1; ex_wb_sel_i = 2'b10;
        applyStimulus(); endCycle();
        clearInputs();
        ex_rs2_addr_i = 5'd1; exmem_pc_i = 32'h100;
        applyStimulus();
`ifdef HAZARD_FWD_EN
        checkOutput("pc4_fwd_sel", 32'(se1_o), 32'd2);
        checkOutput("pc4_fwd_val", fw_c_o, 32'h104);
`endif
        endCycle();

        // LW x7 in EX with ADD x8,x7,x7 in IF/ID
        clearInputs();
        ifid_valid_i = 1'b1; ifid_instr_i = 32'h00738433;
        ex_valid_i = 1'b1; ex_regwrite_i = 1'b1; ex_memread_i = 1'b1;
        ex_rd_addr_i = 5'd7; ex_wb_sel_i = 2'b01;
        applyStimulus();
        checkOutput("loaduse_stall_if", 32'(stall_if_o), 32'd1);
        checkOutput("loaduse_flush_id", 32'(flush_id_o), 32'd1);
        endCycle();
        ex_valid_i = 1'b0; ex_regwrite_i = 1'b0; ex_memread_i = 1'b0;
        ex_rd_addr_i = 5'd0; ex_wb_sel_i = 2'd0;
        applyStimulus();
`ifdef HAZARD_FWD_EN
        checkOutput("loaduse_one_cycle", 32'(stall_if_o), 32'd0);
`endif
        endCycle();
        ifid_instr_i = 32'h00000013;
        ex_valid_i = 1'b1; ex_regwrite_i = 1'b1; ex_rd_addr_i = 5'd8;
        ex_rs1_addr_i = 5'd7; ex_rs2_addr_i = 5'd7;
        wbrf_regwrite_i = 1'b1; wbrf_rd_addr_i = 5'd7; wbrf_wdata_i = 32'h77;
        applyStimulus();
`ifdef HAZARD_FWD_EN
        checkOutput("loaduse_se0", 32'(se0_o), 32'd3);
        checkOutput("loaduse_se1", 32'(se1_o), 32'd3);
`endif
        endCycle();

        // Taken branch during a three-cycle busy period
        clearInputs();
        flushSeen = 0;
        mem_busy_i = 1'b1; bj_taken_i = 1'b1;
        repeat (3) begin
            applyStimulus(); endCycle();
        end
        mem_busy_i = 1'b0; bj_taken_i = 1'b0;
        applyStimulus();
        checkOutput("pend_flush_if", 32'(flush_if_o), 32'd1);
        checkOutput("pend_flush_id", 32'(flush_id_o), 32'd1);
        endCycle();
        applyStimulus(); endCycle();
        checkOutput("pend_flush_cycles", 32'(flushSeen), 32'd1);

        // Reset in the middle of a pending flush
        mem_busy_i = 1'b1; bj_taken_i = 1'b1;
        applyStimulus(); endCycle();
        rst_ni = 1'b0;
        #1;
        checkOutput("reset_over_freeze", 32'(stall_if_o), 32'd0);
        checkOutput("reset_over_branch", 32'(flush_if_o), 32'd0);
        resetModel();
        mem_busy_i = 1'b0; bj_taken_i = 1'b0;
        #1;
        rst_ni = 1'b1;
        applyStimulus();
        checkOutput("pend_dropped", 32'(flush_if_o), 32'd0);
        endCycle();

        // Randomized traffic against the model
        for (int n = 0; n < 600; n++) begin
            randomizeInputs();
            applyStimulus();
            endCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_hazard_unit.md
# rv32i_hazard_unit

Pipeline hazard controller for the five-stage RV32I core: it generates every `stall_*`/`flush_*` input of the core and the EX operand forwarding selects and sources (`se0`/`se1`, `b`/`c`/`d`/`e`). It sits beside the IF→ID→EX→MEM→WB datapath and consumes IF/ID, ID/EX and writeback status. It keeps a shadow of the EX/MEM destination plus a one-deep last-write buffer, so forwarding, load-use interlock, branch flush and memory-busy freeze are decided in one place.

## Interface
Parameters:
- `WB_SEL_MEM`, 2'b01, `wb_sel` code for load data
- `WB_SEL_PC4`, 2'b10, `wb_sel` code for PC+4 (JAL/JALR); any other code is ALU

Ports (one clock; reset is asynchronous and active-low):
- `clk_i` in 1 clock
- `rst_ni` in 1 asynchronous active-low reset
- `ifid_instr_i` in 32 instruction in IF/ID
- `ifid_valid_i` in 1 IF/ID valid
- `ex_rs1_addr_i`, `ex_rs2_addr_i` in 5 each: ID/EX source registers
- `ex_rd_addr_i` in 5 ID/EX rd
- `ex_regwrite_i`, `ex_memread_i`, `ex_valid_i` in 1 each: ID/EX control
- `ex_wb_sel_i` in 2 ID/EX wb select
- `bj_taken_i` in 1 EX branch/jump taken
- `mem_busy_i` in 1 data memory not ready
- `exmem_alu_result_i`, `exmem_pc_i` in 32 each: EX/MEM values
- `wbrf_regwrite_i` in 1, `wbrf_rd_addr_i` in 5, `wbrf_wdata_i` in 32: register-file write port
- `stall_{if,id,ex,mem}_o` out 1 each: hold the stage's output register
- `flush_{if,id,ex,mem}_o` out 1 each: clear the stage's output register valid
- `se0_o`, `se1_o` out 3 each: rs1/rs2 select; 0 = RF, 1 = b, 2 = c, 3 = d, 4 = e
- `fw_b_o`, `fw_c_o`, `fw_d_o`, `fw_e_o` out 32 each: forwarding sources

## Operation
- Shadow `mem_q` = {valid, rd, regwrite, memread, wb_sel} of the EX/MEM instruction.
  - Loads from `ex_*` when `stall_ex_o`=0.
  - Cleared when `flush_ex_o`=1.
- Last-write buffer `lw_q` = {valid, rd, data}.
  - Captures `wbrf_*` every cycle unless frozen.
  - Valid = `wbrf_regwrite_i` && rd≠0.
- Sources:
  - `fw_b_o` = `exmem_alu_result_i`
  - `fw_c_o` = `exmem_pc_i`+4 (mod 2^32)
  - `fw_d_o` = `wbrf_wdata_i`
  - `fw_e_o` = `lw_q.data`
- Per EX operand (rs≠0), first match wins:
  1. `mem_q` regwrite, not memread, rd match: select 2 if wb_sel=`WB_SEL_PC4`, else select 1.
  2. `wbrf` write with rd match: select 3.
  3. `lw_q` match: select 4.
  4. Otherwise select 0.
  - rs=0 always selects 0.
- Decode rs use from `ifid_instr_i[6:0]`:
  - rs1 used except LUI, AUIPC, JAL.
  - rs2 used only by R-type, BRANCH, STORE.
- Load-use: `ifid_valid_i` && `ex_valid_i` && `ex_memread_i` && `ex_rd_addr_i`≠0 && a used rs equals `ex_rd_addr_i`.
  - Response: `stall_if_o`=1, `flush_id_o`=1 (bubble into ID/EX). The load advances.
  - One bubble; the dependent instruction then forwards via select 3.
- States: RUN, FROZEN.
  - RUN→FROZEN when `mem_busy_i`=1; FROZEN→RUN when `mem_busy_i`=0.
  - In FROZEN: all `stall_*_o`=1, all `flush_*_o`=0, `mem_q`/`lw_q` hold, forwarding selects keep evaluating.
- Branch: `bj_taken_i` in RUN with `mem_busy_i`=0 → `flush_if_o`=1 and `flush_id_o`=1 in the same cycle.
  - `bj_taken_i` while busy sets `bj_pend_q`; the flush issues on the first non-busy cycle, then `bj_pend_q` clears.
  - A taken branch in the same cycle as `bj_pend_q` issues a single flush.
- Priority: reset > freeze > branch flush > load-use. A load-use coinciding with a branch flush does not stall.
- `stall_ex_o`, `stall_mem_o`, `flush_ex_o`, `flush_mem_o` are 0 outside freeze.

## Timing
- `stall_*`/`flush_*` are combinational from state + inputs; `se*`/`fw*` are combinational.
- `mem_q`, `lw_q`, `bj_pend_q` and state update on `clk_i` rising edge.
- Reset: state RUN, shadows and `bj_pend_q` cleared, all stall/flush = 0, `se0_o`/`se1_o` = 0, `fw_e_o` = 0.
- Reset asserted mid-freeze or mid-pending drops the pending flush.
- Load-use costs exactly 1 cycle; a branch costs 2 killed slots; freeze lasts exactly the `mem_busy_i` high time.

## Configuration
- `HAZARD_FWD_EN` defined: forwarding as above.
- Undefined: `se0_o`/`se1_o` forced to 0 and `fw_*_o` forced to 0.
  - Interlock replaces forwarding: `stall_if_o`=1 and `flush_id_o`=1 while a used IF/ID rs (≠0) matches any of ID/EX rd (valid regwrite), `mem_q` rd (regwrite), or `wbrf_rd_addr_i` (regwrite).
  - `lw_q` is unused.

## Test plan
- ADD x5 in MEM, ID/EX rs1=x5, `exmem_alu_result_i`=0x1234 -> `se0_o`=1, `fw_b_o`=0x1234.
- JAL rd=x1 in MEM with `exmem_pc_i`=0x100, EX rs2=x1 -> `se1_o`=2, `fw_c_o`=0x104.
- LW x7 in ID/EX, ADD x8,x7,x7 in IF/ID -> one cycle of `stall_if_o`=1/`flush_id_o`=1; next cycle EX selects 3 for both operands.
- `bj_taken_i`=1 with `mem_busy_i`=1 for 3 cycles -> no flush during busy; `flush_if_o`/`flush_id_o`=1 for one cycle after busy drops.
- WB writes x9=0xDEAD while ID reads x9 -> next cycle `se0_o`=4, `fw_e_o`=0xDEAD.
- Without `HAZARD_FWD_EN`: ADD x3 followed by SUB x4,x3,x0 -> three stall cycles (EX, MEM, WB matches), `se0_o`=0 throughout.
